// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for an 8x8 unsigned shift-add multiplier.
// One shared 8-bit adder is reused per iteration; operands and product use valid/ready handshakes.

module adder_8bit (
  input  logic [7:0] M_i,
  input  logic [7:0] N_i,
  output logic [8:0] result_o
);
  assign result_o = {1'b0, M_i} + {1'b0, N_i};
endmodule

module seq_mult_ctrl #(
  parameter logic ZERO_SKIP = 1'b1,
  parameter logic CLEAR_OUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  multiplicand_i,
  input  logic [7:0]  multiplier_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] product_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  m_r;
  logic [7:0]  a_r;
  logic [7:0]  q_r;
  logic [3:0]  cnt_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [15:0] product_r;

  logic [7:0]  addend_s;
  logic [8:0]  sum_s;
  logic [15:0] shifted_s;
  logic        zero_op_s;
  logic        last_iter_s;

  // Adder operands and the next shifted {A,Q} for the current iteration
  always_comb begin
    addend_s    = q_r[0] ? m_r : 8'h00;
    shifted_s   = {sum_s, q_r[7:1]};
    zero_op_s   = (multiplicand_i == 8'h00) || (multiplier_i == 8'h00);
    last_iter_s = (cnt_r == 4'd7);
  end

  adder_8bit u_adder (
    .M_i      (a_r),
    .N_i      (addend_s),
    .result_o (sum_s)
  );

  // Controller FSM with registered handshake, busy and product outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      m_r         <= 8'h00;
      a_r         <= 8'h00;
      q_r         <= 8'h00;
      cnt_r       <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      product_r   <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid_i) begin
            m_r        <= multiplicand_i;
            a_r        <= 8'h00;
            cnt_r      <= 4'd0;
            in_ready_r <= 1'b0;
            if (ZERO_SKIP && zero_op_s) begin
              q_r         <= 8'h00;
              out_valid_r <= 1'b1;
              product_r   <= 16'h0000;
              state_r     <= ST_DONE;
            end else begin
              q_r       <= multiplier_i;
              busy_r    <= 1'b1;
              product_r <= CLEAR_OUT ? 16'h0000 : {8'h00, multiplier_i};
              state_r   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          a_r <= shifted_s[15:8];
          q_r <= shifted_s[7:0];
          // cnt stays inside 0..7: the final iteration wraps it back to zero
          if (last_iter_s) begin
            cnt_r       <= 4'd0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            product_r   <= shifted_s;
            state_r     <= ST_DONE;
          end else begin
            cnt_r     <= cnt_r + 4'd1;
            product_r <= CLEAR_OUT ? 16'h0000 : shifted_s;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            product_r   <= CLEAR_OUT ? 16'h0000 : {a_r, q_r};
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          product_r   <= 16'h0000;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign busy_o      = busy_r;
  assign product_o   = product_r;

endmodule
